// File: rtl/matrix_stream_out.sv
// matrix_stream_out
// Captures one flattened H x W matrix of S-bit elements on a load request and
// streams it out one element per valid/ready handshake, tagged with its
// row/column indices, in row-major or column-major (transposed) order.
// Elements are moved bit-exact; no floating-point interpretation is applied.

module matrix_stream_out #(
    parameter  int S  = 32,
    parameter  int H  = 2,
    parameter  int W  = 2,
    localparam int RW = (H > 1) ? $clog2(H) : 1,
    localparam int CW = (W > 1) ? $clog2(W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              tr,
    input  logic [S*H*W-1:0]  m_in,
    output logic              busy,
    output logic [S-1:0]      out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    // A 1x1 matrix has its only element as the last one.
    localparam logic          FIRST_IS_LAST = ((H == 1) && (W == 1)) ? 1'b1 : 1'b0;

    // Captured matrix held as [row][col]; element (i,j) of m_in is flattened
    // with (0,0) in the MSBs, so the capture loop reorders it.
    logic [H-1:0][W-1:0][S-1:0] mat_q, mat_d;

    state_t          state_q, state_d;
    logic            tr_q, tr_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic [S-1:0]    data_q, data_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;

    logic [RW-1:0]   row_nxt_s;
    logic [CW-1:0]   col_nxt_s;
    logic            xfer_s;

    assign xfer_s = valid_q & out_ready;

    // State register and all datapath/output flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mat_q   <= '0;
            tr_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            mat_q   <= mat_d;
            tr_q    <= tr_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next-state logic: IDLE -> SEND on load, SEND -> DONE on last transfer, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (xfer_s && last_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Index that follows the current one in the latched order; only used when
    // the current element is not the last, so the counters stay in range.
    always_comb begin
        row_nxt_s = row_q;
        col_nxt_s = col_q;
        if (tr_q == 1'b0) begin
            if (col_q == COL_MAX) begin
                col_nxt_s = '0;
                row_nxt_s = row_q + ROW_ONE;
            end else begin
                col_nxt_s = col_q + COL_ONE;
            end
        end else begin
            if (row_q == ROW_MAX) begin
                row_nxt_s = '0;
                col_nxt_s = col_q + COL_ONE;
            end else begin
                row_nxt_s = row_q + ROW_ONE;
            end
        end
    end

    // Output/datapath next values: capture on load, advance on each handshake, pulse done.
    always_comb begin
        mat_d   = mat_q;
        tr_d    = tr_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        data_d  = data_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    for (int i = 0; i < H; i++) begin
                        for (int j = 0; j < W; j++) begin
                            mat_d[i][j] = m_in[S*(H*W-1-(i*W+j)) +: S];
                        end
                    end
                    tr_d    = tr;
                    row_d   = '0;
                    col_d   = '0;
                    data_d  = m_in[S*H*W-1 -: S];
                    last_d  = FIRST_IS_LAST;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    last_d  = 1'b0;
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (xfer_s) begin
                    if (last_q) begin
                        // Final element accepted: keep data/indices, drop valid, pulse done.
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        row_d   = row_nxt_s;
                        col_d   = col_nxt_s;
                        data_d  = mat_q[row_nxt_s][col_nxt_s];
                        last_d  = (row_nxt_s == ROW_MAX) && (col_nxt_s == COL_MAX);
                        valid_d = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Directed testbench for matrix_stream_out: a 2x2 instance and a 2x3 instance,
// row-major and transposed orders, backpressure, load during SEND/DONE and
// mid-stream reset.

module tb_matrix_stream_out;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         tr_in = 1'b0;
    logic         out_ready = 1'b0;
    logic [191:0] mat_bus = '0;
    bit           cur_sel = 1'b0;

    // 2x2 instance
    logic         d22_busy, d22_valid, d22_last, d22_done;
    logic [31:0]  d22_data;
    logic         d22_row, d22_col;
    // 2x3 instance
    logic         d23_busy, d23_valid, d23_last, d23_done;
    logic [31:0]  d23_data;
    logic         d23_row;
    logic [1:0]   d23_col;

    // Observed outputs of whichever instance is under test
    logic         o_busy, o_valid, o_last, o_done, o_row;
    logic [31:0]  o_data;
    logic [1:0]   o_col;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_d [6];
    int          exp_r [6];
    int          exp_c [6];

    always #5 clk = ~clk;

    matrix_stream_out #(.S(32), .H(2), .W(2)) dut (
        .clk(clk), .rst_n(rst_n), .load(load & ~cur_sel), .tr(tr_in),
        .m_in(mat_bus[127:0]), .busy(d22_busy), .out_data(d22_data),
        .out_row(d22_row), .out_col(d22_col), .out_valid(d22_valid),
        .out_ready(out_ready & ~cur_sel), .out_last(d22_last), .done(d22_done)
    );

    matrix_stream_out #(.S(32), .H(2), .W(3)) dut23 (
        .clk(clk), .rst_n(rst_n), .load(load & cur_sel), .tr(tr_in),
        .m_in(mat_bus), .busy(d23_busy), .out_data(d23_data),
        .out_row(d23_row), .out_col(d23_col), .out_valid(d23_valid),
        .out_ready(out_ready & cur_sel), .out_last(d23_last), .done(d23_done)
    );

    assign o_busy  = cur_sel ? d23_busy  : d22_busy;
    assign o_valid = cur_sel ? d23_valid : d22_valid;
    assign o_last  = cur_sel ? d23_last  : d22_last;
    assign o_done  = cur_sel ? d23_done  : d22_done;
    assign o_data  = cur_sel ? d23_data  : d22_data;
    assign o_row   = cur_sel ? d23_row   : d22_row;
    assign o_col   = cur_sel ? d23_col   : {1'b0, d22_col};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_el(input int i, input logic [31:0] d, input int r, input int c);
        exp_d[i] = d;
        exp_r[i] = r;
        exp_c[i] = c;
    endtask

    // Load a matrix and follow the whole stream, comparing every sampled cycle.
    // With noise set, load/m_in/tr are disturbed during SEND and DONE.
    task automatic run_stream(input bit sel, input logic trv, input logic [191:0] mat,
                              input int n_el, input logic [31:0] rdy, input bit noise,
                              input logic [191:0] alt, input string name);
        int n;
        int cyc;
        cur_sel   = sel;
        mat_bus   = mat;
        tr_in     = trv;
        out_ready = 1'b0;
        load      = 1'b1;
        tick();
        load = noise;
        if (noise) begin
            mat_bus = alt;
            tr_in   = ~trv;
        end
        n = 0;
        cyc = 0;
        while (n < n_el && cyc < 100) begin
            out_ready = rdy[cyc % 32];
            tests++;
            if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_done !== 1'b0) begin
                fails++;
                $display("FAIL %s ctl el%0d: valid=%b busy=%b done=%b, expected 1 1 0", name, n, o_valid, o_busy, o_done);
            end
            tests++;
            if (o_data !== exp_d[n]) begin
                fails++;
                $display("FAIL %s data el%0d: got %h expected %h", name, n, o_data, exp_d[n]);
            end
            tests++;
            if (o_row !== exp_r[n][0] || o_col !== exp_c[n][1:0]) begin
                fails++;
                $display("FAIL %s index el%0d: got (%0d,%0d) expected (%0d,%0d)", name, n, o_row, o_col, exp_r[n], exp_c[n]);
            end
            tests++;
            if (o_last !== (n == n_el - 1)) begin
                fails++;
                $display("FAIL %s last el%0d: got %b expected %b", name, n, o_last, (n == n_el - 1));
            end
            tick();
            if (out_ready) n++;
            cyc++;
        end
        tests++;
        if (n < n_el) begin
            fails++;
            $display("FAIL %s timeout: got %0d transfers expected %0d", name, n, n_el);
        end
        out_ready = 1'b0;
        tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s done cycle: done=%b busy=%b valid=%b, expected 1 1 0", name, o_done, o_busy, o_valid);
        end
        tests++;
        if (o_data !== exp_d[n_el-1] || o_row !== exp_r[n_el-1][0] || o_col !== exp_c[n_el-1][1:0]) begin
            fails++;
            $display("FAIL %s done hold: got %h (%0d,%0d) expected %h (%0d,%0d)", name, o_data, o_row, o_col,
                     exp_d[n_el-1], exp_r[n_el-1], exp_c[n_el-1]);
        end
        tick();
        tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s idle: done=%b busy=%b valid=%b, expected 0 0 0", name, o_done, o_busy, o_valid);
        end
    endtask

    localparam logic [127:0] MAT_A = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    localparam logic [127:0] MAT_B = {32'h7FC00000, 32'h00000001, 32'h80000000, 32'hBF800000};
    localparam logic [191:0] MAT_C = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            cur_sel = s[0];
            #0;
            tests++;
            if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0 || o_done !== 1'b0 ||
                o_data !== 32'h0 || o_row !== 1'b0 || o_col !== 2'd0) begin
                fails++;
                $display("FAIL reset%0d: busy=%b valid=%b last=%b done=%b data=%h row=%0d col=%0d, expected all 0",
                         s, o_busy, o_valid, o_last, o_done, o_data, o_row, o_col);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_row_major();
        set_el(0, 32'h3F800000, 0, 0);
        set_el(1, 32'h40000000, 0, 1);
        set_el(2, 32'h40400000, 1, 0);
        set_el(3, 32'h40800000, 1, 1);
        run_stream(1'b0, 1'b0, {64'd0, MAT_A}, 4, 32'hFFFFFFFF, 1'b0, '0, "row_major");
    endtask

    task automatic test_transpose();
        set_el(0, 32'h3F800000, 0, 0);
        set_el(1, 32'h40400000, 1, 0);
        set_el(2, 32'h40000000, 0, 1);
        set_el(3, 32'h40800000, 1, 1);
        run_stream(1'b0, 1'b1, {64'd0, MAT_A}, 4, 32'hFFFFFFFF, 1'b0, '0, "transpose");
    endtask

    task automatic test_backpressure();
        set_el(0, 32'h3F800000, 0, 0);
        set_el(1, 32'h40000000, 0, 1);
        set_el(2, 32'h40400000, 1, 0);
        set_el(3, 32'h40800000, 1, 1);
        run_stream(1'b0, 1'b0, {64'd0, MAT_A}, 4, 32'b1011_0010_1101_0110_1001_1010_0110_0100, 1'b0, '0, "backpressure");
    endtask

    task automatic test_load_ignored();
        set_el(0, 32'h3F800000, 0, 0);
        set_el(1, 32'h40000000, 0, 1);
        set_el(2, 32'h40400000, 1, 0);
        set_el(3, 32'h40800000, 1, 1);
        run_stream(1'b0, 1'b0, {64'd0, MAT_A}, 4, 32'hFFFFFFFF, 1'b1, {64'd0, MAT_B}, "load_busy");
        // New matrix (NaN, denormal, -0 patterns) with transposed order.
        set_el(0, 32'h7FC00000, 0, 0);
        set_el(1, 32'h80000000, 1, 0);
        set_el(2, 32'h00000001, 0, 1);
        set_el(3, 32'hBF800000, 1, 1);
        run_stream(1'b0, 1'b1, {64'd0, MAT_B}, 4, 32'b0110_1101, 1'b0, '0, "reload");
    endtask

    task automatic test_midstream_reset();
        cur_sel   = 1'b0;
        mat_bus   = {64'd0, MAT_A};
        tr_in     = 1'b0;
        out_ready = 1'b1;
        load      = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        tests++;
        if (o_data !== 32'h40400000 || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL midreset pre: data=%h valid=%b, expected 40400000 1", o_data, o_valid);
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0 || o_last !== 1'b0 ||
            o_data !== 32'h0 || o_row !== 1'b0 || o_col !== 2'd0) begin
            fails++;
            $display("FAIL midreset: busy=%b valid=%b done=%b last=%b data=%h row=%0d col=%0d, expected all 0",
                     o_busy, o_valid, o_done, o_last, o_data, o_row, o_col);
        end
        rst_n = 1'b1;
        tick();
        tests++;
        if (o_done !== 1'b0 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL midreset after: done=%b valid=%b busy=%b, expected 0 0 0", o_done, o_valid, o_busy);
        end
        out_ready = 1'b0;
        test_row_major();
    endtask

    task automatic test_2x3();
        set_el(0, 32'd1, 0, 0);
        set_el(1, 32'd2, 0, 1);
        set_el(2, 32'd3, 0, 2);
        set_el(3, 32'd4, 1, 0);
        set_el(4, 32'd5, 1, 1);
        set_el(5, 32'd6, 1, 2);
        run_stream(1'b1, 1'b0, MAT_C, 6, 32'hFFFFFFFF, 1'b0, '0, "2x3_row");
        set_el(0, 32'd1, 0, 0);
        set_el(1, 32'd4, 1, 0);
        set_el(2, 32'd2, 0, 1);
        set_el(3, 32'd5, 1, 1);
        set_el(4, 32'd3, 0, 2);
        set_el(5, 32'd6, 1, 2);
        run_stream(1'b1, 1'b1, MAT_C, 6, 32'b1101_1011_0110, 1'b0, '0, "2x3_tr");
    endtask

    initial begin
        test_reset();
        test_row_major();
        test_transpose();
        test_backpressure();
        test_load_ignored();
        test_midstream_reset();
        test_2x3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
